rx_gearbox: RTL and testbench

- Upstream feeder of the block-offset seeker in the 64b/66b RX recovery path.
- Accepts 32-bit deserialized words and shifts them into a 194-bit window (gbox_buffer).
- Pulses buffer_dv once every two accepted words, i.e. once per 64 new bits.
- Tags each window with a 0..32 sequence count (gbox_cnt); 33 windows of 64 bits = 32 blocks of 66 bits. The downstream seeker uses gbox_cnt to track block slip.

---
 rtl/rx_gearbox.sv | 70 +++++++
 tb/tb_rx_gearbox.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_gearbox.sv
// rx_gearbox: 32-bit word to 194-bit sliding window gearbox with 64-bit-step valid pulses and a 0..32 window sequence count
module rx_gearbox #(
    parameter int DIN_W       = 32,
    parameter int BUF_W       = 194,
    parameter int CNT_MAX     = 32,
    parameter int PRIME_WORDS = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIN_W-1:0] data_i,
    input  logic             data_dv_i,
    input  logic             resync_i,
    output logic [BUF_W-1:0] gbox_buffer,
    output logic             buffer_dv,
    output logic [5:0]       gbox_cnt,
    output logic             word_phase_o,
    output logic             primed_o
);
    localparam int FILL_W = $clog2(PRIME_WORDS + 1);
    localparam logic [FILL_W:0]   PRIME_X = PRIME_WORDS[FILL_W:0];
    localparam logic [FILL_W-1:0] PRIME_F = PRIME_WORDS[FILL_W-1:0];
    localparam logic [5:0]        CNT_M   = CNT_MAX[5:0];

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic              dv_q, dv_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [5:0]        ncnt_q, ncnt_d;
    logic              phase_q, phase_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W:0]   fill_inc;
    logic              pulse;

    // Next-state: shift on accept, pulse on the second word of each pair once primed; resync restarts counting
    always_comb begin
        fill_inc = {1'b0, fill_q} + 1'b1;
        buf_d    = data_dv_i ? {data_i, buf_q[BUF_W-1:DIN_W]} : buf_q;
        pulse    = data_dv_i & phase_q & (fill_inc >= PRIME_X) & ~resync_i;
        dv_d     = pulse;
        phase_d  = resync_i ? data_dv_i : phase_q ^ data_dv_i;
        fill_d   = resync_i ? {{(FILL_W-1){1'b0}}, data_dv_i} :
                   (data_dv_i && fill_q != PRIME_F) ? fill_inc[FILL_W-1:0] : fill_q;
        ncnt_d   = resync_i ? 6'd0 : pulse ? ((ncnt_q == CNT_M) ? 6'd0 : ncnt_q + 6'd1) : ncnt_q;
        cnt_d    = resync_i ? 6'd0 : pulse ? ncnt_q : cnt_q;
    end

    // State registers with synchronous active-low reset taking priority over everything
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            buf_q   <= '0;
            dv_q    <= 1'b0;
            cnt_q   <= '0;
            ncnt_q  <= '0;
            phase_q <= 1'b0;
            fill_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            ncnt_q  <= ncnt_d;
            phase_q <= phase_d;
            fill_q  <= fill_d;
        end
    end

    assign gbox_buffer  = buf_q;
    assign buffer_dv    = dv_q;
    assign gbox_cnt     = cnt_q;
    assign word_phase_o = phase_q;
    assign primed_o     = (fill_q == PRIME_F);
endmodule

// File: tb/tb_rx_gearbox.sv
// tb_rx_gearbox: directed self-checking bench for rx_gearbox
module tb_rx_gearbox;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  data_i = '0;
    logic         data_dv_i = 1'b0;
    logic         resync_i = 1'b0;
    logic [193:0] gbox_buffer;
    logic         buffer_dv;
    logic [5:0]   gbox_cnt;
    logic         word_phase_o;
    logic         primed_o;

    int checks = 0;
    int errors = 0;

    rx_gearbox dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .data_dv_i(data_dv_i),
        .resync_i(resync_i), .gbox_buffer(gbox_buffer), .buffer_dv(buffer_dv),
        .gbox_cnt(gbox_cnt), .word_phase_o(word_phase_o), .primed_o(primed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [193:0] got, input logic [193:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        data_dv_i = 1'b0;
        resync_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        logic [193:0] one;
        logic [193:0] prev_buf;
        logic [5:0]   prev_cnt;
        logic         prev_dv;
        logic [31:0]  last_w;
        int k, last, words;
        one = 194'd1;

        // reset values and first pulse on word 8
        do_reset();
        chk("rst_buf", gbox_buffer, 0);
        chk("rst_dv", buffer_dv, 0);
        chk("rst_cnt", gbox_cnt, 0);
        chk("rst_phase", word_phase_o, 0);
        chk("rst_primed", primed_o, 0);
        for (int i = 1; i <= 8; i++) begin
            data_dv_i = 1'b1;
            data_i = 32'(i);
            tick();
            chk("t1_dv", buffer_dv, (i == 8));
            if (i == 7) begin
                chk("t1_primed7", primed_o, 1);
                chk("t1_phase7", word_phase_o, 1);
            end
            if (i == 6) chk("t1_primed6", primed_o, 0);
        end
        data_dv_i = 1'b0;
        chk("t1_cnt", gbox_cnt, 0);
        chk("t1_top", gbox_buffer[193:162], 32'h8);
        chk("t1_w7", gbox_buffer[161:130], 32'h7);
        chk("t1_w3", gbox_buffer[33:2], 32'h3);
        chk("t1_tail", gbox_buffer[1:0], 2'b00);
        tick();
        chk("t1_dv_off", buffer_dv, 0);

        // continuous input, 74 pulses with wrapping count
        do_reset();
        data_dv_i = 1'b1;
        k = 0;
        last = 0;
        prev_dv = 1'b0;
        for (int cyc = 0; cyc < 400 && k < 74; cyc++) begin
            data_i = $urandom;
            tick();
            if (buffer_dv) begin
                chk("t2_adj", prev_dv, 0);
                if (k == 0) chk("t2_first", cyc, 7);
                else chk("t2_gap", cyc - last, 2);
                chk("t2_cnt", gbox_cnt, 194'(k % 33));
                last = cyc;
                k++;
            end
            prev_dv = buffer_dv;
        end
        data_dv_i = 1'b0;
        chk("t2_npulse", k, 74);
        tick();

        // gapped input, one word every 8 cycles
        do_reset();
        words = 0;
        for (int cyc = 0; cyc < 8 * 20; cyc++) begin
            data_dv_i = (cyc % 8 == 0);
            data_i = 32'(cyc + 1);
            prev_buf = gbox_buffer;
            prev_cnt = gbox_cnt;
            if (data_dv_i) words++;
            tick();
            if (data_dv_i) begin
                chk("t3_dv", buffer_dv, (words >= 8 && words % 2 == 0));
                if (words >= 8 && words % 2 == 0) chk("t3_cnt", gbox_cnt, 194'((words - 8) / 2));
            end else begin
                chk("t3_dv_idle", buffer_dv, 0);
                chk("t3_hold_buf", gbox_buffer, prev_buf);
                chk("t3_hold_cnt", gbox_cnt, prev_cnt);
            end
        end
        data_dv_i = 1'b0;

        // resync after the window tagged 20
        do_reset();
        data_dv_i = 1'b1;
        k = 0;
        last_w = '0;
        for (int cyc = 0; cyc < 200 && k == 0; cyc++) begin
            data_i = 32'(cyc + 100);
            last_w = data_i;
            tick();
            if (buffer_dv && gbox_cnt == 6'd20) k = 1;
        end
        chk("t4_reach20", k, 1);
        resync_i = 1'b1;
        data_i = 32'hA5A5_0001;
        tick();
        resync_i = 1'b0;
        chk("t4_phase", word_phase_o, 1);
        chk("t4_primed", primed_o, 0);
        chk("t4_dv", buffer_dv, 0);
        chk("t4_cnt", gbox_cnt, 0);
        chk("t4_top", gbox_buffer[193:162], 32'hA5A5_0001);
        chk("t4_kept", gbox_buffer[161:130], last_w);
        for (int i = 2; i <= 8; i++) begin
            data_i = 32'(i);
            tick();
            chk("t4_dv_w", buffer_dv, (i == 8));
        end
        chk("t4_cnt8", gbox_cnt, 0);
        data_dv_i = 1'b0;
        tick();

        // reset on the edge that would raise buffer_dv
        do_reset();
        data_dv_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            data_i = 32'(i);
            tick();
        end
        data_i = 32'h8;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk("t5_dv", buffer_dv, 0);
        chk("t5_buf", gbox_buffer, 0);
        chk("t5_cnt", gbox_cnt, 0);
        chk("t5_phase", word_phase_o, 0);
        chk("t5_primed", primed_o, 0);
        for (int i = 1; i <= 8; i++) begin
            data_i = 32'(i + 16);
            tick();
            chk("t5_dv_w", buffer_dv, (i == 8));
        end
        chk("t5_cnt8", gbox_cnt, 0);
        data_dv_i = 1'b0;

        // walking one through the window
        do_reset();
        data_dv_i = 1'b1;
        data_i = 32'h20;
        tick();
        chk("t6_w1", gbox_buffer, one << 167);
        data_i = '0;
        for (int i = 2; i <= 7; i++) begin
            tick();
            if (i == 6) chk("t6_w6", gbox_buffer, one << 7);
            if (i == 7) chk("t6_w7", gbox_buffer, 0);
        end
        data_dv_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
